// File: rtl/csa_accumulator_pkg.sv
// Shared types and defaults for the carry-save packet accumulator.
// Also holds the full-adder cell that the compressor row is built from.
package csa_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_e;

   localparam int DEF_N     = 32;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_W     = DEF_N + DEF_CNT_W;

   // Full-adder cell: returns {carry, sum}.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
      full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

endpackage

// File: rtl/csa_accumulator_csa_row.sv
// W-bit 3:2 compressor: a+b+c == sum_o + carry_o (mod 2^W).
module csa_row
   import csa_accumulator_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   output logic [W-1:0] sum_o,
   output logic [W-1:0] carry_o
);

   logic [W-1:0] maj_s;

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign {maj_s[i], sum_o[i]} = full_add(a_i[i], b_i[i], c_i[i]);
   end

   // Carry weight moves up one bit; the top carry falls off (mod 2^W).
   assign carry_o = maj_s << 1;

endmodule

// File: rtl/csa_accumulator.sv
// Packet accumulator keeping a redundant sum/carry pair while beats arrive,
// then resolving the carries in place before presenting the result.
module csa_accumulator
   import csa_accumulator_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N+CNT_W-1:0]   out_sum,
   output logic [CNT_W:0]       out_count,
   output logic                 overflow
);

   localparam int W = N + CNT_W;
   localparam logic [CNT_W:0] CNT_MAX = {1'b1, {CNT_W{1'b0}}};
   localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [W-1:0]     s_q, s_d;
   logic [W-1:0]     c_q, c_d;
   logic [CNT_W:0]   cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             in_ready_q;
   logic             out_valid_q;

   logic             accept_s;
   logic [W-1:0]     x_s;
   logic [W-1:0]     row_sum_s;
   logic [W-1:0]     row_carry_s;

   assign accept_s = in_valid & in_ready_q;
   assign x_s      = {{CNT_W{1'b0}}, in_data};

   csa_row #(.W(W)) u_row (
      .a_i     (s_q),
      .b_i     (c_q),
      .c_i     (x_s),
      .sum_o   (row_sum_s),
      .carry_o (row_carry_s)
   );

   // Next-state, datapath and counter update.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      sum_d   = sum_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               s_d     = x_s;
               c_d     = '0;
               cnt_d   = CNT_ONE;
               ovf_d   = 1'b0;
               state_d = in_last ? RESOLVE : ACCUM;
            end else begin
               state_d = IDLE;
            end
         end
         ACCUM: begin
            if (accept_s) begin
               s_d = row_sum_s;
               c_d = row_carry_s;
               if (cnt_q == CNT_MAX) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               state_d = in_last ? RESOLVE : ACCUM;
            end else begin
               state_d = ACCUM;
            end
         end
         RESOLVE: begin
            // With no carries left, S alone is the sum.
            if (c_q == '0) begin
               sum_d   = s_q;
               state_d = DONE;
            end else begin
               s_d = s_q ^ c_q;
               c_d = (s_q & c_q) << 1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         s_q         <= '0;
         c_q         <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         sum_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         c_q         <= c_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         sum_q       <= sum_d;
         in_ready_q  <= (state_d == IDLE) || (state_d == ACCUM);
         out_valid_q <= (state_d == DONE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign out_count = cnt_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Randomized self-checking bench for csa_accumulator against a plain-arithmetic
// packet-sum model.
module tb_csa_accumulator;

   localparam int N     = 32;
   localparam int CNT_W = 8;
   localparam int W     = N + CNT_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [N-1:0]      in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_sum;
   logic [CNT_W:0]    out_count;
   logic              overflow;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] pkt_q[$];

   always #5 clk = ~clk;

   csa_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .overflow  (overflow)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive every beat in pkt_q; random idle gaps, optional last flag on the final beat.
   task automatic send_pkt(input int gap_pct, input bit mark_last);
      int budget;
      for (int i = 0; i < pkt_q.size(); i++) begin
         if (int'($urandom_range(99, 0)) < gap_pct) begin
            in_valid = 1'b0;
            repeat ($urandom_range(3, 1)) @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = pkt_q[i];
         in_last  = mark_last && (i == pkt_q.size() - 1);
         budget   = 200;
         while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         if (budget == 0) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            i = pkt_q.size();
         end else begin
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Wait for the result, compare against the model, hold for stall cycles, release.
   task automatic expect_result(input string tag, input int stall, output int lat);
      logic [63:0] exp_sum;
      logic [63:0] exp_cnt;
      logic        exp_ovf;
      exp_sum = 64'd0;
      foreach (pkt_q[i]) exp_sum = exp_sum + 64'(pkt_q[i]);
      exp_sum = exp_sum & ((64'd1 << W) - 64'd1);
      exp_cnt = (pkt_q.size() > 256) ? 64'd256 : 64'(pkt_q.size());
      exp_ovf = (pkt_q.size() > 256);
      lat = 1;
      while (!out_valid && lat < W + 8) begin
         @(negedge clk);
         lat++;
      end
      check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_sum"},   64'(out_sum),   exp_sum);
      check_eq({tag, "_count"}, 64'(out_count), exp_cnt);
      check_eq({tag, "_ovf"},   64'(overflow),  64'(exp_ovf));
      out_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         check_eq({tag, "_hold_rdy"},   64'(in_ready),  64'd0);
         check_eq({tag, "_hold_sum"},   64'(out_sum),   exp_sum);
         check_eq({tag, "_hold_cnt"},   64'(out_count), exp_cnt);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
      check_eq({tag, "_rel_rdy"},   64'(in_ready),  64'd1);
   endtask

   initial begin
      int lat;
      int len;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_rdy",   64'(in_ready),  64'd0);
      check_eq("rst_valid", 64'(out_valid), 64'd0);
      check_eq("rst_sum",   64'(out_sum),   64'd0);
      check_eq("rst_count", 64'(out_count), 64'd0);
      check_eq("rst_ovf",   64'(overflow),  64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_rdy", 64'(in_ready), 64'd1);

      // Basic packet, stalled in DONE for 5 cycles.
      pkt_q = '{32'd5, 32'd7, 32'd9};
      send_pkt(0, 1'b1);
      expect_result("basic", 5, lat);
      check_eq("basic_lit_sum", 64'(out_sum), 64'd21);

      // Single all-ones beat and its latency bound.
      pkt_q = '{32'hFFFF_FFFF};
      send_pkt(0, 1'b1);
      expect_result("single", 0, lat);
      check_eq("single_lat_ok", 64'(lat <= W + 2), 64'd1);

      // Saturation boundary: 256 beats, then 257 beats.
      pkt_q.delete();
      repeat (256) pkt_q.push_back(32'hFFFF_FFFF);
      send_pkt(0, 1'b1);
      expect_result("b256", 1, lat);
      pkt_q.push_back(32'hFFFF_FFFF);
      send_pkt(10, 1'b1);
      expect_result("b257", 1, lat);

      // Reset in the middle of a packet discards it.
      pkt_q = '{32'd3, 32'd4};
      send_pkt(0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_valid", 64'(out_valid), 64'd0);
      check_eq("midrst_rdy",   64'(in_ready),  64'd0);
      check_eq("midrst_sum",   64'(out_sum),   64'd0);
      check_eq("midrst_count", 64'(out_count), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_rdy_back", 64'(in_ready), 64'd1);
      pkt_q = '{32'd10, 32'd20};
      send_pkt(0, 1'b1);
      expect_result("after_rst", 0, lat);

      // Random packets with gaps and output stalls.
      for (int p = 0; p < 8; p++) begin
         len = (p == 0) ? 300 : int'($urandom_range(300, 1));
         pkt_q.delete();
         for (int b = 0; b < len; b++) begin
            pkt_q.push_back(($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : $urandom);
         end
         send_pkt(30, 1'b1);
         expect_result($sformatf("rand%0d", p), int'($urandom_range(3, 0)), lat);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
